// File: rtl/bin2bcd.sv
// Sequential binary-to-BCD converter (double-dabble, one input bit per clock) with start/busy/done framing.
// Result registers change only on completion; inputs above 9999 saturate the display to 9999 and flag ovf.
module bin2bcd #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [15:0]      scratch;
    logic [CW-1:0]    cnt;
    logic             sat;
    logic             accept;
    logic [15:0]      bin_ext;
    logic             in_sat;
    logic [14:0]      adj;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    assign bin_ext = 16'(bin);
    assign in_sat  = bin_ext > 16'd9999;

    // Top nibble keeps only its low three bits: its MSB is shifted out and discarded.
    assign adj[3:0]   = add3(scratch[3:0]);
    assign adj[7:4]   = add3(scratch[7:4]);
    assign adj[11:8]  = add3(scratch[11:8]);
    assign adj[14:12] = (scratch[15:12] >= 4'd5) ? scratch[14:12] + 3'd3 : scratch[14:12];

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // busy is its own flop so multi-bit state transitions cannot glitch it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            sat     <= 1'b0;
        end else if (accept) begin
            shreg   <= bin;
            scratch <= '0;
            cnt     <= '0;
            sat     <= in_sat;
        end else if (state == SHIFT) begin
            scratch <= {adj, shreg[WIDTH-1]};
            shreg   <= {shreg[WIDTH-2:0], 1'b0};
            cnt     <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd  <= 16'h0000;
            ovf  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (state == DONE) begin
                bcd <= sat ? 16'h9999 : scratch;
                ovf <= sat;
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd.sv
// Directed bench for bin2bcd: expected results are queued at start and compared when done pulses.
module tb_bin2bcd;

    localparam int WIDTH = 14;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] bin;
    logic             busy;
    logic             done;
    logic [15:0]      bcd;
    logic             ovf;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [16:0] sb_q[$];

    bin2bcd #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .bcd  (bcd),
        .ovf  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    function automatic logic [15:0] exp_bcd(input int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v);
        sb_q.push_back({exp_bcd(v), (v > 9999) ? 1'b1 : 1'b0});
    endtask

    task automatic compare_out(input string tag);
        logic [16:0] e;
        if (sb_q.size() == 0) begin
            check({tag, "_unexpected_done"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_bcd"}, bcd, e[16:1]);
            check({tag, "_ovf"}, ovf, e[0]);
        end
    endtask

    task automatic wait_done(output int cyc, output bit got);
        cyc = 0;
        got = 0;
        while (!got && cyc < 40) begin
            tick();
            cyc++;
            if (done) got = 1;
        end
    endtask

    task automatic run(input string tag, input int v);
        int  cyc;
        int  busy_hi;
        bit  got;
        bin   = WIDTH'(v);
        start = 1'b1;
        push(v);
        tick();
        start = 1'b0;
        bin   = WIDTH'($urandom_range(0, 16383));
        check({tag, "_busy_after_accept"}, busy, 1);
        cyc = 0;
        busy_hi = 1;
        got = 0;
        while (!got && cyc < 40) begin
            tick();
            cyc++;
            if (done) got = 1;
            else if (busy) busy_hi++;
        end
        check({tag, "_done_seen"}, got, 1);
        check({tag, "_latency"}, cyc, WIDTH + 1);
        check({tag, "_busy_cycles"}, busy_hi, WIDTH + 1);
        check({tag, "_busy_low_at_done"}, busy, 0);
        compare_out(tag);
        tick();
        check({tag, "_done_one_cycle"}, done, 0);
    endtask

    initial begin
        int  cyc;
        int  d0;
        int  d1;
        int  d2;
        bit  got;

        rst   = 1'b0;
        start = 1'b0;
        bin   = '0;
        #3 rst = 1'b1;
        tick();
        tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_bcd", bcd, 16'h0000);
        check("reset_ovf", ovf, 0);
        rst = 1'b0;
        tick();

        run("c1234", 1234);
        repeat (5) tick();
        check("hold_bcd", bcd, 16'h1234);
        check("hold_busy", busy, 0);

        run("c0", 0);
        run("c9999", 9999);
        run("c10", 10);
        run("c10000", 10000);
        run("c16383", 16383);
        run("c42", 42);
        run("c509", 509);

        // A start pulse during SHIFT must be ignored.
        d0    = done_cnt;
        bin   = WIDTH'(5678);
        start = 1'b1;
        push(5678);
        tick();
        start = 1'b0;
        bin   = '0;
        repeat (4) tick();
        bin   = WIDTH'(1111);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc, got);
        check("ign_done_seen", got, 1);
        check("ign_latency", cyc + 5, WIDTH + 1);
        compare_out("ign");
        repeat (20) tick();
        check("ign_single_done", done_cnt - d0, 1);
        check("ign_idle", busy, 0);

        // start held high: back-to-back conversions every WIDTH+2 cycles.
        bin   = WIDTH'(100);
        start = 1'b1;
        push(100);
        tick();
        bin = WIDTH'(200);
        push(200);
        cyc = 0;
        d1  = -1;
        d2  = -1;
        while (cyc < 45 && d2 < 0) begin
            tick();
            cyc++;
            if (done) begin
                compare_out("b2b");
                if (d1 < 0) d1 = cyc;
                else d2 = cyc;
            end
            if (cyc == WIDTH + 2) begin
                check("b2b_done_fell", done, 0);
                check("b2b_restart_busy", busy, 1);
                start = 1'b0;
            end
        end
        check("b2b_first_done", d1, WIDTH + 1);
        check("b2b_second_done", d2, 2 * WIDTH + 3);
        tick();
        check("b2b_done_one_cycle", done, 0);
        check("b2b_bcd_hold", bcd, 16'h0200);

        // Asynchronous reset in the middle of a conversion.
        bin   = WIDTH'(4321);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_bcd", bcd, 16'h0000);
        check("abort_ovf", ovf, 0);
        d0 = done_cnt;
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle", busy, 0);
        run("c4321", 4321);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
